// File: rtl/bp_iteration_scheduler.sv
// Top-level sequencer for the belief-propagation LDPC decoder: walks the datapath through
// LLR load, check-node update, variable-node update and syndrome check until convergence.
module bp_iteration_scheduler #(
  parameter int NUM_VARS   = 4,
  parameter int NUM_CHECKS = 2,
  parameter int MAX_ITER   = 5,
  parameter int IDX_W      = 2,
  parameter int ITER_W     = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              syndrome_ok,
  output logic              load_en,
  output logic              cn_en,
  output logic              vn_en,
  output logic              syn_en,
  output logic [IDX_W-1:0]  row_idx,
  output logic [IDX_W-1:0]  col_idx,
  output logic [ITER_W-1:0] iter_count,
  output logic              busy,
  output logic              done,
  output logic              converged
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CN,
    VN,
    SYN,
    DONE
  } state_t;

  localparam logic [IDX_W-1:0]  LAST_VAR   = IDX_W'(NUM_VARS - 1);
  localparam logic [IDX_W-1:0]  LAST_CHECK = IDX_W'(NUM_CHECKS - 1);
  localparam logic [ITER_W-1:0] LAST_ITER  = ITER_W'(MAX_ITER - 1);

  state_t state;

  // Every output is loaded together with the state it belongs to, so the enables,
  // indices and status flags are all plain flops with no decode logic behind them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      load_en    <= 1'b0;
      cn_en      <= 1'b0;
      vn_en      <= 1'b0;
      syn_en     <= 1'b0;
      row_idx    <= '0;
      col_idx    <= '0;
      iter_count <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      converged  <= 1'b0;
    end else if (abort) begin
      // Abandon quietly: no done pulse, and the iteration count is left for inspection.
      state     <= IDLE;
      load_en   <= 1'b0;
      cn_en     <= 1'b0;
      vn_en     <= 1'b0;
      syn_en    <= 1'b0;
      row_idx   <= '0;
      col_idx   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      converged <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state      <= LOAD;
            load_en    <= 1'b1;
            busy       <= 1'b1;
            row_idx    <= '0;
            col_idx    <= '0;
            iter_count <= '0;
            converged  <= 1'b0;
          end
        end

        LOAD: begin
          if (col_idx == LAST_VAR) begin
            state   <= CN;
            load_en <= 1'b0;
            cn_en   <= 1'b1;
            col_idx <= '0;
            row_idx <= '0;
          end else begin
            col_idx <= col_idx + 1'b1;
          end
        end

        CN: begin
          if (row_idx == LAST_CHECK) begin
            state   <= VN;
            cn_en   <= 1'b0;
            vn_en   <= 1'b1;
            row_idx <= '0;
            col_idx <= '0;
          end else begin
            row_idx <= row_idx + 1'b1;
          end
        end

        VN: begin
          if (col_idx == LAST_VAR) begin
            state   <= SYN;
            vn_en   <= 1'b0;
            syn_en  <= 1'b1;
            col_idx <= '0;
          end else begin
            col_idx <= col_idx + 1'b1;
          end
        end

        // A passing syndrome always ends the decode, even on the final iteration.
        SYN: begin
          syn_en <= 1'b0;
          if (syndrome_ok) begin
            state     <= DONE;
            done      <= 1'b1;
            converged <= 1'b1;
          end else if (iter_count == LAST_ITER) begin
            state     <= DONE;
            done      <= 1'b1;
            converged <= 1'b0;
          end else begin
            state      <= CN;
            cn_en      <= 1'b1;
            row_idx    <= '0;
            iter_count <= iter_count + 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end

        default: begin
          state   <= IDLE;
          load_en <= 1'b0;
          cn_en   <= 1'b0;
          vn_en   <= 1'b0;
          syn_en  <= 1'b0;
          row_idx <= '0;
          col_idx <= '0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bp_iteration_scheduler.sv
// Directed bench for bp_iteration_scheduler: per-cycle schedule checks for several decodes,
// plus abort, start/abort collision, and asynchronous reset scenarios.
module tb_bp_iteration_scheduler;

  localparam int NV = 4;
  localparam int NC = 2;
  localparam int MI = 5;
  localparam int IW = 2;
  localparam int TW = 3;
  localparam int L  = NC + NV + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          syndrome_ok = 1'b0;
  logic          load_en, cn_en, vn_en, syn_en, busy, done, converged;
  logic [IW-1:0] row_idx, col_idx;
  logic [TW-1:0] iter_count;

  int errors = 0;
  int checks = 0;

  bp_iteration_scheduler #(
    .NUM_VARS(NV), .NUM_CHECKS(NC), .MAX_ITER(MI), .IDX_W(IW), .ITER_W(TW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .syndrome_ok(syndrome_ok),
    .load_en(load_en), .cn_en(cn_en), .vn_en(vn_en), .syn_en(syn_en),
    .row_idx(row_idx), .col_idx(col_idx), .iter_count(iter_count),
    .busy(busy), .done(done), .converged(converged)
  );

  always #5 clk = ~clk;

  // Packed view: {load,cn,vn,syn,done,busy,conv,row,col,iter}
  logic [13:0] act;
  assign act = {load_en, cn_en, vn_en, syn_en, done, busy, converged, row_idx, col_idx, iter_count};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    tick();
    tick();
    checks++;
    if (act !== 14'd0) begin
      errors++;
      $display("[TB] FAIL reset_hold: got %b expected %b", act, 14'd0);
    end
    reset = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++;
      if (act !== 14'd0) begin
        errors++;
        $display("[TB] FAIL idle_no_start c%0d: got %b expected %b", c, act, 14'd0);
      end
    end
  endtask

  // conv_iter: iteration (0-based) whose syndrome passes, or -1 for never.
  task automatic run_decode(input int conv_iter, input bit hold_start, input string name);
    int k;
    int done_c;
    int p;
    int it;
    bit is_syn;
    logic [13:0] exp;
    logic [6:0] fl;
    logic [IW-1:0] er, ec;
    logic [TW-1:0] ei;
    k = (conv_iter >= 0) ? conv_iter + 1 : MI;
    done_c = 1 + NV + k * L;
    start = 1'b1;
    syndrome_ok = 1'b1;
    for (int c = 1; c <= done_c + 3; c++) begin
      tick();
      fl = 7'd0; er = '0; ec = '0; ei = '0; is_syn = 1'b0; it = 0;
      if (c <= NV) begin
        fl = 7'b1000010;
        ec = IW'(c - 1);
      end else if (c < done_c) begin
        p  = (c - 1 - NV) % L;
        it = (c - 1 - NV) / L;
        ei = TW'(it);
        if (p < NC) begin
          fl = 7'b0100010;
          er = IW'(p);
        end else if (p < NC + NV) begin
          fl = 7'b0010010;
          ec = IW'(p - NC);
        end else begin
          fl = 7'b0001010;
          is_syn = 1'b1;
        end
      end else if (c == done_c) begin
        fl = {5'b00001, 1'b1, (conv_iter >= 0)};
        ei = TW'(k - 1);
      end else begin
        fl = {6'b000000, (conv_iter >= 0)};
        ei = TW'(k - 1);
      end
      exp = {fl, er, ec, ei};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("[TB] FAIL %s c%0d: got %b expected %b", name, c, act, exp);
      end
      start = hold_start && (c < done_c);
      syndrome_ok = is_syn ? (it == conv_iter) : 1'b1;
    end
    start = 1'b0;
    syndrome_ok = 1'b0;
  endtask

  task automatic test_abort_start_idle;
    // Previous decode left iter_count=2, converged=1.
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if (act !== {7'b0000000, 2'd0, 2'd0, 3'd2}) begin
      errors++;
      $display("[TB] FAIL abort_start_idle: got %b expected %b", act, {7'b0000000, 2'd0, 2'd0, 3'd2});
    end
    tick();
    checks++;
    if (busy !== 1'b0 || load_en !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_start_stay: got busy=%b load=%b expected 0 0", busy, load_en);
    end
  endtask

  task automatic test_abort_mid_vn;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 2; c <= 8; c++) tick();
    checks++;
    if (vn_en !== 1'b1 || col_idx !== 2'd1) begin
      errors++;
      $display("[TB] FAIL abort_pre_vn: got vn=%b col=%0d expected 1 1", vn_en, col_idx);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (act !== 14'd0) begin
      errors++;
      $display("[TB] FAIL abort_mid_vn: got %b expected %b", act, 14'd0);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL abort_no_done c%0d: got done=%b busy=%b expected 0 0", c, done, busy);
      end
    end
    run_decode(1, 1'b0, "after_abort");
  endtask

  task automatic test_reset_mid_cn;
    start = 1'b1;
    for (int c = 1; c <= 5; c++) tick();
    checks++;
    if (cn_en !== 1'b1 || row_idx !== 2'd0 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_pre_cn: got cn=%b row=%0d busy=%b expected 1 0 1", cn_en, row_idx, busy);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (act !== 14'd0) begin
      errors++;
      $display("[TB] FAIL async_reset_mid_cn: got %b expected %b", act, 14'd0);
    end
    start = 1'b0;
    tick();
    reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (act !== 14'd0) begin
        errors++;
        $display("[TB] FAIL post_reset_idle c%0d: got %b expected %b", c, act, 14'd0);
      end
    end
  endtask

  initial begin
    test_reset();
    run_decode(0, 1'b1, "early_conv");
    run_decode(-1, 1'b0, "max_iter");
    run_decode(2, 1'b1, "conv_third");
    test_abort_start_idle();
    test_abort_mid_vn();
    test_reset_mid_cn();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
